// File: rtl/rot_enc_pkg.sv
// rot_enc_pkg -- shared constants and helpers for the rotary encoder decoder.
//   MOVE_NONE / MOVE_INC / MOVE_DEC : encodings of the 2-bit move output
//   DETENT_AB                       : {a,b} code of the mechanical rest position
//   cw_next()                       : clockwise successor of an {a,b} code
//   classify()                      : kind of step between two {a,b} codes
package rot_enc_pkg;

  localparam logic [1:0] MOVE_NONE = 2'b00;
  localparam logic [1:0] MOVE_INC  = 2'b10;
  localparam logic [1:0] MOVE_DEC  = 2'b01;
  localparam logic [1:0] DETENT_AB = 2'b00;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_ILLEGAL
  } step_e;

  // Clockwise Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // A step is CCW when the old code is the clockwise successor of the new
  // one; anything that is neither CW, CCW nor "no change" flipped both bits.
  function automatic step_e classify(input logic [1:0] prev_ab,
                                     input logic [1:0] cur_ab);
    step_e s;
    if (cur_ab == prev_ab)               s = STEP_NONE;
    else if (cur_ab == cw_next(prev_ab)) s = STEP_CW;
    else if (prev_ab == cw_next(cur_ab)) s = STEP_CCW;
    else                                 s = STEP_ILLEGAL;
    return s;
  endfunction

endpackage

// File: rtl/rot_enc_debounce.sv
// rot_enc_debounce -- 2-flop synchronizer followed by a run-length debouncer
// for one raw, bouncy input bit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   raw_i        : raw asynchronous input
//   stable_o     : registered debounced value
//   stable_d_o   : value stable_o takes at the next edge; lets a consumer
//                  register its reaction in the same edge as the update
// The stable value changes only after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from it.
module rot_enc_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic stable_d_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any sample equal to the stable value restarts the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o   = stable_q;
  assign stable_d_o = stable_d;

endmodule

// File: rtl/rot_enc_decoder.sv
// rot_enc_decoder -- quadrature rotary encoder decoder with per-channel
// synchronizer/debounce, signed step accumulator and one move per detent.
//   clk, rst_n    : clock, asynchronous active-low reset
//   rot_a, rot_b  : raw encoder channels (asynchronous, bouncy)
//   move          : one-cycle command, 10 = increment (CW), 01 = decrement
//   quad_err      : one-cycle pulse when both channels change at once
// Optional feature, enabled by defining ROT_ENC_CENTER_EN:
//   rot_center    : raw push-button input
//   center_press  : one-cycle pulse on the debounced 0->1 edge
module rot_enc_decoder
  import rot_enc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rot_a,
  input  logic       rot_b,
`ifdef ROT_ENC_CENTER_EN
  input  logic       rot_center,
  output logic       center_press,
`endif
  output logic [1:0] move,
  output logic       quad_err
);

  localparam int ACC_MAX = STEPS_PER_DETENT + 1;
  localparam int ACC_W   = $clog2(ACC_MAX + 1) + 1;

  localparam logic signed [ACC_W-1:0] ACC_HI  = ACC_W'(ACC_MAX);
  localparam logic signed [ACC_W-1:0] ACC_LO  = ACC_W'(-ACC_MAX);
  localparam logic signed [ACC_W-1:0] THR_P   = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] THR_N   = ACC_W'(-STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic [1:0] raw_ab;
  logic [1:0] stable_ab;  // debounced {a,b} as of the last edge = prev AB
  logic [1:0] next_ab;    // debounced {a,b} after the coming edge

  assign raw_ab = {rot_a, rot_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      rot_enc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_i      (raw_ab[gi]),
        .stable_o   (stable_ab[gi]),
        .stable_d_o (next_ab[gi])
      );
    end
  endgenerate

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_step;
  logic [1:0]              move_q;
  logic [1:0]              move_d;
  logic                    quad_err_q;
  logic                    quad_err_d;
  step_e                   step;

  // The transition is evaluated on the value the debounced pair is about to
  // take, so move/quad_err are registered on the very edge the pair changes.
  always_comb begin
    step       = classify(stable_ab, next_ab);
    acc_step   = acc_q;
    quad_err_d = 1'b0;
    move_d     = MOVE_NONE;
    case (step)
      STEP_CW:      if (acc_q < ACC_HI) acc_step = acc_q + ACC_ONE;
      STEP_CCW:     if (acc_q > ACC_LO) acc_step = acc_q - ACC_ONE;
      STEP_ILLEGAL: quad_err_d = 1'b1;
      default:      ;
    endcase
    acc_d = acc_step;
    // Arriving at the detent decides on the count including this last step;
    // whatever the outcome the partial count is dropped.
    if (step != STEP_NONE && next_ab == DETENT_AB) begin
      if (acc_step >= THR_P)      move_d = MOVE_INC;
      else if (acc_step <= THR_N) move_d = MOVE_DEC;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      move_q     <= MOVE_NONE;
      quad_err_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      move_q     <= move_d;
      quad_err_q <= quad_err_d;
    end
  end

  assign move     = move_q;
  assign quad_err = quad_err_q;

`ifdef ROT_ENC_CENTER_EN
  logic center_stable;
  logic center_next;
  logic center_press_q;
  logic center_press_d;

  rot_enc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_center (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_i      (rot_center),
    .stable_o   (center_stable),
    .stable_d_o (center_next)
  );

  assign center_press_d = center_next & ~center_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      center_press_q <= 1'b0;
    end else begin
      center_press_q <= center_press_d;
    end
  end

  assign center_press = center_press_q;
`endif

endmodule

// File: tb/tb_rot_enc_decoder.sv
`timescale 1ns/1ps
module tb_rot_enc_decoder;

  localparam int DB  = 4;
  localparam int SPD = 4;
  localparam logic [1:0] EXP_INC = 2'b10;
  localparam logic [1:0] EXP_DEC = 2'b01;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rot_a = 1'b0;
  logic       rot_b = 1'b0;
  logic [1:0] move;
  logic       quad_err;
`ifdef ROT_ENC_CENTER_EN
  logic       rot_center = 1'b0;
  logic       center_press;
`endif

  rot_enc_decoder #(
    .DEBOUNCE_CYCLES  (DB),
    .STEPS_PER_DETENT (SPD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rot_a        (rot_a),
    .rot_b        (rot_b),
`ifdef ROT_ENC_CENTER_EN
    .rot_center   (rot_center),
    .center_press (center_press),
`endif
    .move         (move),
    .quad_err     (quad_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Channel 0 is A, channel 1 is B.  Position of a code on the Gray wheel
  // gives direction by modular difference.
  bit         m_s1[2];
  bit         m_s2[2];
  bit         m_stable[2];
  bit         m_hist[2][$];
  int         m_acc;
  logic [1:0] m_move;
  bit         m_err;

  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_s1[ch] = 0; m_s2[ch] = 0; m_stable[ch] = 0;
      m_hist[ch].delete();
    end
    m_acc = 0; m_move = 2'b00; m_err = 0;
  endtask

  task automatic model_step();
    bit raw[2];
    logic [1:0] old_ab, new_ab;
    bit all_diff;
    int d;
    raw[0] = rot_a; raw[1] = rot_b;
    old_ab = {m_stable[0], m_stable[1]};
    for (int ch = 0; ch < 2; ch++) begin
      bit smp;
      smp = m_s2[ch];
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = raw[ch];
      m_hist[ch].push_back(smp);
      if (m_hist[ch].size() > DB) void'(m_hist[ch].pop_front());
      all_diff = (m_hist[ch].size() == DB);
      foreach (m_hist[ch][k]) if (m_hist[ch][k] == m_stable[ch]) all_diff = 0;
      if (all_diff) m_stable[ch] = ~m_stable[ch];
    end
    new_ab = {m_stable[0], m_stable[1]};
    m_move = 2'b00;
    m_err  = 0;
    if (new_ab != old_ab) begin
      d = (pos(new_ab) - pos(old_ab) + 4) % 4;
      if (d == 1)      m_acc = (m_acc + 1 > SPD + 1) ? SPD + 1 : m_acc + 1;
      else if (d == 3) m_acc = (m_acc - 1 < -(SPD + 1)) ? -(SPD + 1) : m_acc - 1;
      else             m_err = 1;
      if (new_ab == 2'b00) begin
        if (m_acc >= SPD)       m_move = EXP_INC;
        else if (m_acc <= -SPD) m_move = EXP_DEC;
        m_acc = 0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int cnt_inc, cnt_dec, cnt_err, cnt_ctr;

  task automatic clear_counts();
    cnt_inc = 0; cnt_dec = 0; cnt_err = 0; cnt_ctr = 0;
  endtask

  // One clock: advance the model at the edge, compare just after it.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    chk({tag, "_move"}, int'(move), int'(m_move));
    chk({tag, "_qerr"}, int'(quad_err), int'(m_err));
    if (move == EXP_INC) cnt_inc++;
    if (move == EXP_DEC) cnt_dec++;
    if (quad_err)        cnt_err++;
`ifdef ROT_ENC_CENTER_EN
    if (center_press)    cnt_ctr++;
`endif
  endtask

  task automatic hold(input int n, input string tag);
    repeat (n) tick(tag);
  endtask

  task automatic drive(input logic [1:0] ab);
    rot_a = ab[1];
    rot_b = ab[0];
  endtask

  typedef struct {
    string      name;
    logic [1:0] ab;
    int         n;
    int         inc;
    int         dec;
    int         err;
  } seg_t;

  seg_t tbl[$];

  function automatic void add(input string name, input logic [1:0] ab, input int n,
                              input int inc, input int dec, input int err);
    seg_t s;
    s.name = name; s.ab = ab; s.n = n; s.inc = inc; s.dec = dec; s.err = err;
    tbl.push_back(s);
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int first;
    logic [1:0] cur;
    int dir;

    // ---- vector table: clean rotations, half turn, illegal jumps ----
    add("cw_a",   2'b01, 10, 0, 0, 0);
    add("cw_b",   2'b11, 10, 0, 0, 0);
    add("cw_c",   2'b10, 10, 0, 0, 0);
    add("cw_det", 2'b00, 10, 1, 0, 0);
    for (int r = 0; r < 2; r++) begin
      add("ccw_a",   2'b10, 10, 0, 0, 0);
      add("ccw_b",   2'b11, 10, 0, 0, 0);
      add("ccw_c",   2'b01, 10, 0, 0, 0);
      add("ccw_det", 2'b00, 10, 0, 1, 0);
    end
    add("half_a",   2'b01, 10, 0, 0, 0);
    add("half_b",   2'b11, 10, 0, 0, 0);
    add("half_c",   2'b01, 10, 0, 0, 0);
    add("half_det", 2'b00, 10, 0, 0, 0);
    add("jump_11",  2'b11, 10, 0, 0, 1);
    add("jump_00",  2'b00, 10, 0, 0, 1);
    add("pj_a",     2'b01, 10, 0, 0, 0);
    add("pj_jump",  2'b10, 10, 0, 0, 1);
    add("pj_det",   2'b00, 10, 0, 0, 0);
    add("cw2_a",    2'b01, 10, 0, 0, 0);
    add("cw2_b",    2'b11, 10, 0, 0, 0);
    add("cw2_c",    2'b10, 10, 0, 0, 0);
    add("cw2_det",  2'b00, 10, 1, 0, 0);

    // ---- reset state ----
    model_reset();
    clear_counts();
    hold(3, "reset");
    chk("reset_move", int'(move), 0);
    chk("reset_qerr", int'(quad_err), 0);
    rst_n = 1'b1;
    hold(5, "idle");

    // ---- table-driven segments ----
    foreach (tbl[i]) begin
      drive(tbl[i].ab);
      clear_counts();
      hold(tbl[i].n, tbl[i].name);
      chk({tbl[i].name, "_inc"}, cnt_inc, tbl[i].inc);
      chk({tbl[i].name, "_dec"}, cnt_dec, tbl[i].dec);
      chk({tbl[i].name, "_err"}, cnt_err, tbl[i].err);
      $display("seg %-8s ab=%b inc=%0d dec=%0d err=%0d", tbl[i].name, tbl[i].ab,
               cnt_inc, cnt_dec, cnt_err);
    end

    // ---- latency of the move pulse after the final raw edge, then async reset ----
    drive(2'b01); hold(10, "lat");
    drive(2'b11); hold(10, "lat");
    drive(2'b10); hold(10, "lat");
    drive(2'b00);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick("lat");
      if (move == EXP_INC) begin
        first = k;
        break;
      end
    end
    chk("cw_latency", first, 6);
    $display("latency cycles=%0d", first);
    rst_n = 1'b0;
    #1;
    chk("async_rst_move", int'(move), 0);
    model_reset();
    hold(2, "arst");
    rst_n = 1'b1;
    hold(5, "arst_idle");

    // ---- glitches on A at the detent never reach the decoder ----
    clear_counts();
    for (int g = 0; g < 5; g++) begin
      drive(2'b10); hold(3, "glitch");
      drive(2'b00); hold(10, "glitch");
    end
    chk("glitch_inc", cnt_inc, 0);
    chk("glitch_dec", cnt_dec, 0);
    chk("glitch_err", cnt_err, 0);
    $display("glitch x5 inc=%0d dec=%0d err=%0d", cnt_inc, cnt_dec, cnt_err);
    clear_counts();
    drive(2'b01); hold(10, "post_glitch");
    drive(2'b11); hold(10, "post_glitch");
    drive(2'b10); hold(10, "post_glitch");
    drive(2'b00); hold(10, "post_glitch");
    chk("post_glitch_inc", cnt_inc, 1);
    chk("post_glitch_err", cnt_err, 0);

    // ---- reset in the middle of a rotation discards partial steps ----
    clear_counts();
    drive(2'b01); hold(10, "midrst");
    drive(2'b11); hold(10, "midrst");
    rst_n = 1'b0;
    drive(2'b00);
    hold(3, "midrst");
    rst_n = 1'b1;
    hold(20, "midrst");
    chk("midrst_inc", cnt_inc, 0);
    chk("midrst_dec", cnt_dec, 0);
    chk("midrst_err", cnt_err, 0);
    $display("midrst inc=%0d dec=%0d err=%0d", cnt_inc, cnt_dec, cnt_err);

`ifdef ROT_ENC_CENTER_EN
    // ---- push button with a short bounce at the start ----
    clear_counts();
    rot_center = 1'b1; hold(1, "ctr");
    rot_center = 1'b0; hold(1, "ctr");
    rot_center = 1'b1; hold(10, "ctr");
    rot_center = 1'b0; hold(10, "ctr");
    chk("center_press_count", cnt_ctr, 1);
    $display("center presses=%0d", cnt_ctr);
`endif

    // ---- randomized walk against the reference model ----
    cur = 2'b00;
    dir = 1;
    clear_counts();
    for (int t = 0; t < 200; t++) begin
      int r;
      logic [1:0] nxt;
      int p;
      r = int'($urandom_range(0, 99));
      p = pos(cur);
      if (r < 20) dir = -dir;
      if (r < 80)      p = (p + dir + 4) % 4;
      else if (r < 88) p = (p + 2) % 4;
      case (p)
        0:       nxt = 2'b00;
        1:       nxt = 2'b01;
        2:       nxt = 2'b11;
        default: nxt = 2'b10;
      endcase
      if (r >= 88) nxt = cur ^ ((r % 2 == 0) ? 2'b10 : 2'b01);
      cur = nxt;
      drive(cur);
      if (r == 99) begin
        rst_n = 1'b0;
        hold(2, "rnd_rst");
        rst_n = 1'b1;
      end
      hold(int'($urandom_range(1, 14)), "rnd");
      $display("rnd %0d ab=%b inc=%0d dec=%0d err=%0d", t, cur, cnt_inc, cnt_dec, cnt_err);
    end
    drive(2'b00);
    hold(20, "rnd_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
